// File: rtl/clmul_seq_if.sv
// Operand/result handshake bundle between the execute stage and the clmul_seq sequencer.
// The execute stage uses the master modport and the sequencer uses the slave modport.
interface clmul_seq_if #(
    parameter int WIDTH = 32
);
    logic             StartValid;
    logic             StartReady;
    logic [1:0]       Op;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic             Flush;
    logic             Busy;
    logic             ResultValid;
    logic             ResultReady;
    logic [WIDTH-1:0] ClmulResult;

    modport master (
        output StartValid, Op, X, Y, Flush, ResultReady,
        input  StartReady, Busy, ResultValid, ClmulResult
    );

    modport slave (
        input  StartValid, Op, X, Y, Flush, ResultReady,
        output StartReady, Busy, ResultValid, ClmulResult
    );
endinterface

// File: rtl/clmul_seq.sv
// Multi-cycle carry-less multiplier (clmul/clmulh/clmulr), BITSPERCYCLE partial products per cycle.
// Optional CLMUL_SEQ_EARLYOUT_EN finishes as soon as the remaining Y bits are all zero.
module clmul_seq #(
    parameter int WIDTH        = 32,
    parameter int BITSPERCYCLE = 4
) (
    input  logic        clk,
    input  logic        resetn,
    clmul_seq_if.slave  bus
);
    localparam int N  = WIDTH / BITSPERCYCLE;
    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] COUNT_END = CW'(N);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state, state_next;
    logic [2*WIDTH-1:0] xs, p, pp;
    logic [WIDTH-1:0]   ys, ys_shift, result, result_sel;
    logic [1:0]         op_r;
    logic [CW-1:0]      count, count_inc;
    logic               start, consume, select;

    // The cycle after the final consume is spent registering the selected slice.
    assign start    = (state == IDLE) && bus.StartValid && !bus.Flush;
    assign consume  = (state == BUSY) && (count != COUNT_END);
    assign select   = (state == BUSY) && (count == COUNT_END) && !bus.Flush;
    assign ys_shift = ys >> BITSPERCYCLE;

`ifdef CLMUL_SEQ_EARLYOUT_EN
    assign count_inc = (ys_shift == '0) ? COUNT_END : count + 1'b1;
`else
    assign count_inc = count + 1'b1;
`endif

    always_comb begin
        pp = '0;
        for (int k = 0; k < BITSPERCYCLE; k++) begin
            if (ys[k]) pp = pp ^ (xs << k);
        end
    end

    always_comb begin
        case (op_r)
            2'b01:   result_sel = p[2*WIDTH-1:WIDTH];
            2'b10:   result_sel = p[2*WIDTH-2:WIDTH-1];
            default: result_sel = p[WIDTH-1:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    // NOTE: combinational blocks assign a default first so every path drives a value and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = BUSY;
            BUSY: begin
                if (bus.Flush)               state_next = IDLE;
                else if (count == COUNT_END) state_next = DONE;
            end
            DONE: if (bus.Flush || bus.ResultReady) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            p      <= '0;
            count  <= '0;
            result <= '0;
        end else begin
            if (start) begin
                p     <= '0;
                count <= '0;
            end else if (consume) begin
                p     <= p ^ pp;
                count <= count_inc;
            end
            if (select) result <= result_sel;
        end
    end

    // NOTE: operand shift registers carry no reset; they are always loaded on a start before being consumed.
    always_ff @(posedge clk) begin
        if (start) begin
            xs   <= {{WIDTH{1'b0}}, bus.X};
            ys   <= bus.Y;
            op_r <= bus.Op;
        end else if (consume) begin
            xs <= xs << BITSPERCYCLE;
            ys <= ys_shift;
        end
    end

    assign bus.StartReady  = (state == IDLE);
    assign bus.Busy        = (state != IDLE);
    assign bus.ResultValid = (state == DONE);
    assign bus.ClmulResult = result;
endmodule
